// File: rtl/dc_vlc_slice_sequencer.sv
// Purpose: streams one slice of DC coefficients gap-free through the DC entropy encoder and queues the codewords.
// Latency: first codeword enters the FIFO ENC_LATENCY+2 cycles after the first coefficient read; done 2 cycles after the last capture.
// Backpressure: the encoder cannot stall, so a slice is only issued once the FIFO has room for all of it; cw_ready throttles the FIFO only.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start_i, num_blocks_i slice request and block count (clamped to MAX_BLOCKS)
//   busy_o, done_o        slice in progress / one-cycle completion pulse
//   slice_bits_o          saturating sum of codeword lengths of the current/last slice
//   len_err_o             sticky: encoder reported a length above 32 in this slice
//   coef_rd_*             coefficient buffer read port (data one cycle after the strobe)
//   enc_*                 encoder reset, coefficient input and codeword outputs
//   cw_*                  codeword FIFO head toward the bitstream packer (valid/ready)
module dc_vlc_slice_sequencer #(
    parameter int MAX_BLOCKS  = 32,
    parameter int ENC_LATENCY = 6,
    parameter int FIFO_DEPTH  = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic [5:0]  num_blocks_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] slice_bits_o,
    output logic        len_err_o,
    output logic        coef_rd_en_o,
    output logic [4:0]  coef_rd_addr_o,
    input  logic [31:0] coef_rd_data_i,
    output logic        enc_reset_n_o,
    output logic [31:0] enc_dc_coeff_o,
    input  logic [31:0] enc_sum_i,
    input  logic [31:0] enc_len_i,
    output logic        cw_valid_o,
    input  logic        cw_ready_i,
    output logic [31:0] cw_data_o,
    output logic [5:0]  cw_len_o,
    output logic        cw_last_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          n_q, n_d;
    logic [5:0]          rd_cnt_q, rd_cnt_d;
    logic [5:0]          cap_cnt_q, cap_cnt_d;
    logic [ENC_LATENCY:0] vsr_q;
    logic                enc_rst_n_q, enc_rst_n_d;
    logic [15:0]         acc_q, acc_d;
    logic                len_err_q, len_err_d;
    logic                busy_q, busy_d;
    logic                done_q;
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       cnt_q;
    logic [38:0]         mem_q [FIFO_DEPTH];

    logic                accept;
    logic [5:0]          n_clamped;
    logic [6:0]          free_w;
    logic                rd_en;
    logic                cap;
    logic                cap_last;
    logic                push, pop;
    logic [5:0]          cap_len;
    logic [32:0]         acc_sum;

    assign accept    = start_i && !busy_q && (state_q == S_IDLE);
    assign n_clamped = (num_blocks_i > 6'(MAX_BLOCKS)) ? 6'(MAX_BLOCKS) : num_blocks_i;
    // Captures of the current slice are already reserved by the admission check,
    // so the FIFO occupancy alone is the right measure of free space here.
    assign free_w    = 7'(FIFO_DEPTH) - 7'(cnt_q);

    // vsr_q[0] marks the cycle a coefficient sits on enc_dc_coeff_o;
    // vsr_q[ENC_LATENCY] marks the cycle its codeword is on enc_sum_i/enc_len_i.
    assign cap      = vsr_q[ENC_LATENCY];
    assign cap_last = (cap_cnt_q == n_q - 6'd1);
    assign cap_len  = (enc_len_i > 32'd32) ? 6'd32 : enc_len_i[5:0];
    assign acc_sum  = {17'd0, acc_q} + {1'b0, enc_len_i};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (n_clamped == 6'd0) begin
                        state_d = S_DONE;
                    end else if (free_w >= {1'b0, n_clamped}) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (free_w >= {1'b0, n_q}) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rd_cnt_q == n_q - 6'd1) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cap && cap_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rd_en          = (state_q == S_ISSUE);
        coef_rd_en_o   = rd_en;
        coef_rd_addr_o = rd_en ? rd_cnt_q[4:0] : 5'd0;
        enc_dc_coeff_o = vsr_q[0] ? coef_rd_data_i : 32'd0;
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        n_d         = n_q;
        rd_cnt_d    = rd_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        enc_rst_n_d = enc_rst_n_q;
        acc_d       = acc_q;
        len_err_d   = len_err_q;
        busy_d      = busy_q;

        if (accept) begin
            n_d       = n_clamped;
            rd_cnt_d  = 6'd0;
            cap_cnt_d = 6'd0;
            acc_d     = 16'd0;
            len_err_d = 1'b0;
            busy_d    = 1'b1;
        end else if (done_q) begin
            // busy stays high through the done cycle and drops right after
            busy_d = 1'b0;
        end

        if (rd_en) begin
            rd_cnt_d = rd_cnt_q + 6'd1;
            // Released one cycle ahead so the encoder leaves reset exactly
            // when block 0 reaches its input.
            if (rd_cnt_q == 6'd0) begin
                enc_rst_n_d = 1'b1;
            end
        end

        if (cap) begin
            cap_cnt_d = cap_cnt_q + 6'd1;
            acc_d     = (acc_sum > 33'h0FFFF) ? 16'hFFFF : acc_sum[15:0];
            if (enc_len_i > 32'd32) begin
                len_err_d = 1'b1;
            end
            if (cap_last) begin
                enc_rst_n_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_q         <= 6'd0;
            rd_cnt_q    <= 6'd0;
            cap_cnt_q   <= 6'd0;
            vsr_q       <= '0;
            enc_rst_n_q <= 1'b0;
            acc_q       <= 16'd0;
            len_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            n_q         <= n_d;
            rd_cnt_q    <= rd_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            vsr_q       <= {vsr_q[ENC_LATENCY-1:0], rd_en};
            enc_rst_n_q <= enc_rst_n_d;
            acc_q       <= acc_d;
            len_err_q   <= len_err_d;
            busy_q      <= busy_d;
            done_q      <= (state_q == S_DONE);
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign slice_bits_o  = acc_q;
    assign len_err_o     = len_err_q;
    assign enc_reset_n_o = enc_rst_n_q;

    // ---------------- codeword FIFO ----------------
    assign push = cap;
    assign pop  = cw_valid_o && cw_ready_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Storage is not reset: the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {enc_sum_i, cap_len, cap_last};
        end
    end

    assign cw_valid_o = (cnt_q != '0);
    assign cw_data_o  = cw_valid_o ? mem_q[rd_ptr_q][38:7] : 32'd0;
    assign cw_len_o   = cw_valid_o ? mem_q[rd_ptr_q][6:1]  : 6'd0;
    assign cw_last_o  = cw_valid_o ? mem_q[rd_ptr_q][0]    : 1'b0;

endmodule

// File: tb/tb_dc_vlc_slice_sequencer.sv
// Purpose: self-checking bench for dc_vlc_slice_sequencer with coefficient-buffer and encoder models.
// Latency: expected codewords are queued at slice start and compared whenever the FIFO hands one over.
// Backpressure: cw_ready is driven constant, randomly, or by an exact pop budget.
module tb_dc_vlc_slice_sequencer;

    localparam int MAXB = 32;
    localparam int LAT  = 6;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [5:0]  num_blocks;
    logic        busy, done, len_err;
    logic [15:0] slice_bits;
    logic        coef_rd_en;
    logic [4:0]  coef_rd_addr;
    logic [31:0] coef_rd_data;
    logic        enc_reset_n;
    logic [31:0] enc_dc_coeff;
    logic [31:0] enc_sum, enc_len;
    logic        cw_valid;
    logic        cw_ready = 1'b0;
    logic [31:0] cw_data;
    logic [5:0]  cw_len;
    logic        cw_last;

    dc_vlc_slice_sequencer #(
        .MAX_BLOCKS(MAXB), .ENC_LATENCY(LAT), .FIFO_DEPTH(32)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .start_i(start), .num_blocks_i(num_blocks),
        .busy_o(busy), .done_o(done), .slice_bits_o(slice_bits), .len_err_o(len_err),
        .coef_rd_en_o(coef_rd_en), .coef_rd_addr_o(coef_rd_addr), .coef_rd_data_i(coef_rd_data),
        .enc_reset_n_o(enc_reset_n), .enc_dc_coeff_o(enc_dc_coeff),
        .enc_sum_i(enc_sum), .enc_len_i(enc_len),
        .cw_valid_o(cw_valid), .cw_ready_i(cw_ready),
        .cw_data_o(cw_data), .cw_len_o(cw_len), .cw_last_o(cw_last)
    );

    // ---------------- bookkeeping ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // ---------------- clock ----------------
    bit clk_run = 0;
    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- golden DC encoder ----------------
    // Codeword for the difference to the previous coefficient of the slice
    // (0 for the first): signed-to-unsigned fold, then exp-Golomb order 0.
    // Result {bits, length}; f40 forces an illegal length of 40.
    function automatic logic [63:0] golden(input logic [31:0] cur, input logic [31:0] prv, input bit f40);
        int d;
        int unsigned z, x, len;
        int nb;
        d = int'(cur - prv);
        if (d >= 0) z = 2 * d;
        else        z = -2 * d - 1;
        x   = z + 1;
        nb  = $clog2(x + 1);
        len = 2 * nb - 1;
        if (f40) len = 40;
        return {x, len};
    endfunction

    // ---------------- coefficient buffer model ----------------
    logic [31:0] coef_mem [MAXB];
    int read_cnt = 0;
    always @(posedge clk) begin
        if (coef_rd_en) begin
            coef_rd_data <= coef_mem[coef_rd_addr];
            read_cnt     <= read_cnt + 1;
        end
    end

    // ---------------- cycle-level encoder model ----------------
    bit          force40 = 0;
    logic [31:0] pred;
    logic [63:0] pipe [LAT];
    always @(posedge clk) begin
        if (!enc_reset_n) pred <= 32'd0;
        else              pred <= enc_dc_coeff;
        pipe[0] <= enc_reset_n ? golden(enc_dc_coeff, pred, force40) : 64'd0;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign enc_sum = pipe[LAT-1][63:32];
    assign enc_len = pipe[LAT-1][31:0];

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] d;
        logic [5:0]  l;
        logic        last;
    } cw_t;

    cw_t         exp_cw[$];
    int          exp_bits[$];
    bit          exp_err[$];
    logic [31:0] exp_first[$];

    int pops_seen = 0;
    int pop_limit = 0;
    int rdy_mode  = 0;   // 0 hold low, 1 hold high, 2 random, 3 pop budget

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       cw_ready = 1'b0;
            1:       cw_ready = 1'b1;
            2:       cw_ready = 1'($urandom_range(0, 1));
            default: cw_ready = (pops_seen < pop_limit);
        endcase
    end

    cw_t  mon_e;
    logic enc_rst_prev = 1'b0;
    int   mon_bits;
    bit   mon_err;
    always @(negedge clk) begin
        if (cw_valid && cw_ready) begin
            pops_seen++;
            if (exp_cw.size() == 0) begin
                fail_now("unexpected codeword");
            end else begin
                mon_e = exp_cw.pop_front();
                check("codeword {data,len,last}", {25'd0, cw_data, cw_len, cw_last}, {25'd0, mon_e});
            end
        end
        if (done) begin
            if (exp_bits.size() == 0) begin
                fail_now("unexpected done");
            end else begin
                mon_bits = exp_bits.pop_front();
                mon_err  = exp_err.pop_front();
                check("slice_bits at done", 64'(slice_bits), 64'(mon_bits));
                check("len_err at done", 64'(len_err), 64'(mon_err));
            end
        end
        if (enc_reset_n && !enc_rst_prev) begin
            if (exp_first.size() == 0) fail_now("unexpected encoder release");
            else check("coef on enc_reset_n rise", 64'(enc_dc_coeff), 64'(exp_first.pop_front()));
        end
        enc_rst_prev = enc_reset_n;
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] stim_coef [MAXB];

    task automatic fill_random();
        for (int i = 0; i < MAXB; i++) stim_coef[i] = $urandom_range(0, 4000);
    endtask

    // Loads the buffer, queues the expected slice outcome, pulses start.
    task automatic start_slice(input int n);
        int          nn, bits;
        int unsigned len;
        bit          err;
        logic [31:0] prv;
        logic [63:0] g;
        cw_t         e;
        nn   = (n > MAXB) ? MAXB : n;
        prv  = 32'd0;
        bits = 0;
        err  = 0;
        for (int i = 0; i < nn; i++) begin
            coef_mem[i] = stim_coef[i];
            g   = golden(stim_coef[i], prv, force40);
            prv = stim_coef[i];
            len = g[31:0];
            if (len > 32) err = 1;
            e.d    = g[63:32];
            e.l    = (len > 32) ? 6'd32 : len[5:0];
            e.last = (i == nn - 1);
            exp_cw.push_back(e);
            bits = bits + int'(len);
            if (bits > 65535) bits = 65535;
        end
        exp_bits.push_back(bits);
        exp_err.push_back(err);
        if (nn > 0) exp_first.push_back(stim_coef[0]);
        @(posedge clk); #1;
        num_blocks = 6'(n);
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk);
            if (!busy) return;
        end
        fail_now(name);
    endtask

    task automatic wait_drained(input string name, input int maxc);
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk);
            if (exp_cw.size() == 0 && !cw_valid) return;
        end
        fail_now(name);
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, " busy"}, 64'(busy), 0);
        check({tag, " done"}, 64'(done), 0);
        check({tag, " len_err"}, 64'(len_err), 0);
        check({tag, " coef_rd_en"}, 64'(coef_rd_en), 0);
        check({tag, " coef_rd_addr"}, 64'(coef_rd_addr), 0);
        check({tag, " cw_valid"}, 64'(cw_valid), 0);
        check({tag, " cw_last"}, 64'(cw_last), 0);
        check({tag, " slice_bits"}, 64'(slice_bits), 0);
        check({tag, " enc_dc_coeff"}, 64'(enc_dc_coeff), 0);
        check({tag, " enc_reset_n"}, 64'(enc_reset_n), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rc;
        reset_n    = 1'b0;
        start      = 1'b0;
        num_blocks = 6'd0;

        // 1. reset with the clock idle
        #5;
        chk_reset_vals("reset");
        #5;
        reset_n = 1'b1;
        clk_run = 1;
        repeat (2) @(posedge clk);

        // 2. fixed 4-block slice: codes of deltas 100,0,1,-3 -> lengths 15,1,3,5
        rdy_mode = 1;
        stim_coef[0] = 32'd100;
        stim_coef[1] = 32'd100;
        stim_coef[2] = 32'd101;
        stim_coef[3] = 32'd98;
        start_slice(4);
        check("busy after start", 64'(busy), 1);
        wait_idle("slice4 done", 100);
        check("slice4 slice_bits", 64'(slice_bits), 24);
        wait_drained("slice4 drain", 100);

        // 3. two 20-block slices with the packer stalled
        rdy_mode  = 3;
        pop_limit = pops_seen;
        fill_random();
        start_slice(20);
        wait_idle("stall slice A done", 200);
        fill_random();
        rc = read_cnt;
        start_slice(20);
        repeat (10) @(negedge clk);
        check("WAIT: no reads with 20 queued", 64'(read_cnt - rc), 0);
        check("WAIT: busy held", 64'(busy), 1);
        pop_limit = pops_seen + 7;
        repeat (20) @(negedge clk);
        check("WAIT: seven pops taken", 64'(pops_seen), 64'(pop_limit));
        check("WAIT: still no reads after 7 pops", 64'(read_cnt - rc), 0);
        pop_limit = pop_limit + 1;
        begin
            bit seen = 0;
            for (int k = 0; k < 30 && !seen; k++) begin
                @(negedge clk);
                if (read_cnt != rc) seen = 1;
            end
            if (seen) check("ISSUE after 8th pop", 64'(read_cnt != rc), 1);
            else      fail_now("ISSUE after 8th pop");
        end
        rdy_mode = 1;
        wait_idle("stall slice B done", 300);
        wait_drained("stall drain", 300);

        // 4. empty slice: done two cycles after start, nothing read or queued
        rc = read_cnt;
        exp_bits.push_back(0);
        exp_err.push_back(0);
        @(posedge clk); #1;
        num_blocks = 6'd0;
        start      = 1'b1;
        @(negedge clk);
        check("N=0 done cycle0", 64'(done), 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("N=0 done cycle1", 64'(done), 0);
        @(negedge clk);
        check("N=0 done cycle2", 64'(done), 1);
        wait_idle("N=0 idle", 20);
        check("N=0 no reads", 64'(read_cnt - rc), 0);
        check("N=0 no codewords", 64'(cw_valid), 0);

        // 5. asynchronous reset in the middle of issuing 16 blocks
        fill_random();
        rc = read_cnt;
        start_slice(16);
        begin
            bit seen = 0;
            for (int k = 0; k < 50 && !seen; k++) begin
                @(negedge clk);
                if (read_cnt - rc >= 4) seen = 1;
            end
            if (!seen) fail_now("mid-slice reads");
        end
        check("mid-slice busy", 64'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("mid-slice reset");
        exp_cw.delete();
        exp_bits.delete();
        exp_err.delete();
        exp_first.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        fill_random();
        start_slice(3);
        wait_idle("post-reset slice done", 100);
        wait_drained("post-reset drain", 100);

        // 6. start while busy is ignored; encoder reports length 40
        force40 = 1;
        fill_random();
        rc = read_cnt;
        start_slice(5);
        @(posedge clk); #1;
        num_blocks = 6'd7;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        wait_idle("busy-start slice done", 100);
        check("busy-start reads", 64'(read_cnt - rc), 5);
        check("len_err sticky", 64'(len_err), 1);
        check("saturating bits 5x40", 64'(slice_bits), 200);
        force40 = 0;
        wait_drained("len40 drain", 100);

        // 7. random slices (including N=0 and N>32) with random backpressure
        rdy_mode = 2;
        for (int r = 0; r < 12; r++) begin
            fill_random();
            start_slice($urandom_range(0, 40));
            wait_idle("random slice done", 3000);
        end
        rdy_mode = 1;
        wait_drained("random drain", 500);
        repeat (5) @(negedge clk);
        check("pending done count", 64'(exp_bits.size()), 0);
        check("pending encoder releases", 64'(exp_first.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
